// File: rtl/ultra_sonic_multi_pkg.sv
// rtl/ultra_sonic_multi_pkg.sv - shared types and default timing constants for the ultrasonic ranger
package ultra_sonic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIGGER,
        S_WAIT_ECHO,
        S_ON_ECHO,
        S_REPORT,
        S_STALL
    } us_state_e;

    // Defaults for a 50 MHz clock
    localparam int DEF_TRIGGER_CYCLES = 500;        // 10 us trigger pulse
    localparam int DEF_TIMEOUT_CYCLES = 1_900_000;  // 38 ms echo window
    localparam int DEF_STALL_CYCLES   = 3_000_000;  // 60 ms between shots
    localparam int CM_DIVISOR         = 2915;       // echo cycles per centimetre

endpackage

// File: rtl/ultra_sonic_multi_if.sv
// rtl/ultra_sonic_multi_if.sv - result stream towards the memory-map/FIFO layer
interface ultra_sonic_multi_if #(
    parameter int CH_W        = 2,
    parameter int COUNT_WIDTH = 24
);
    logic                   out_valid;
    logic                   out_ready;
    logic [CH_W-1:0]        out_chan;
    logic [COUNT_WIDTH-1:0] out_count;
    logic                   out_timeout;

    modport master (output out_valid, output out_chan, output out_count, output out_timeout,
                    input  out_ready);
    modport slave  (input  out_valid, input  out_chan, input  out_count, input  out_timeout,
                    output out_ready);
endinterface

// File: rtl/us_echo_sync.sv
// rtl/us_echo_sync.sv - per-bit two-flop synchroniser for the asynchronous echo inputs
module us_echo_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // two flops per bit; only the second stage is used downstream
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;
endmodule

// File: rtl/ultra_sonic_multi.sv
// rtl/ultra_sonic_multi.sv - round-robin multi-channel HC-SR04 style ranger with result stream
module ultra_sonic_multi
    import ultra_sonic_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int COUNT_WIDTH    = 24,
    parameter int TRIGGER_CYCLES = DEF_TRIGGER_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int STALL_CYCLES   = DEF_STALL_CYCLES,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [NUM_CH-1:0]   chan_enable,
    input  logic [NUM_CH-1:0]   echo,
    output logic [NUM_CH-1:0]   trigger,
    output logic                busy,
    ultra_sonic_multi_if.master out_if
);
    localparam int TRG_W = $clog2(TRIGGER_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int STL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [TRG_W-1:0] TRG_LAST = TRG_W'(TRIGGER_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [STL_W-1:0] STL_LAST = STL_W'(STALL_CYCLES - 1);

    us_state_e              state_q, state_d;
    logic [CH_W-1:0]        cur_chan_q, cur_chan_d;
    logic [TRG_W-1:0]       trig_cnt_q, trig_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [STL_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [COUNT_WIDTH-1:0] echo_cnt_q, echo_cnt_d, echo_inc;
    logic [CH_W-1:0]        res_chan_q, res_chan_d;
    logic [COUNT_WIDTH-1:0] res_count_q, res_count_d;
    logic                   res_timeout_q, res_timeout_d;
    logic [NUM_CH-1:0]      trigger_q;
    logic                   out_valid_q;
    logic                   echo_prev_q;
    logic [NUM_CH-1:0]      sync_echo;
    logic                   echo_cur;
    logic [CH_W-1:0]        sel_here, sel_next;
    int                     best_here, best_next;

    us_echo_sync #(.WIDTH(NUM_CH)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (echo),
        .sync_o  (sync_echo)
    );

    assign echo_cur = sync_echo[cur_chan_q];
    // the count pins at all-ones instead of wrapping
    assign echo_inc = (&echo_cnt_q) ? echo_cnt_q : echo_cnt_q + COUNT_WIDTH'(1);

    // nearest enabled channel at-or-after cur_chan (sel_here) and strictly after it (sel_next), wrapping
    always_comb begin
        best_here = NUM_CH;
        best_next = NUM_CH;
        sel_here  = cur_chan_q;
        sel_next  = cur_chan_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (chan_enable[i] && ((i - int'(cur_chan_q) + NUM_CH) % NUM_CH) < best_here) begin
                best_here = (i - int'(cur_chan_q) + NUM_CH) % NUM_CH;
                sel_here  = CH_W'(i);
            end
            if (chan_enable[i] && ((i - int'(cur_chan_q) + NUM_CH - 1) % NUM_CH) < best_next) begin
                best_next = (i - int'(cur_chan_q) + NUM_CH - 1) % NUM_CH;
                sel_next  = CH_W'(i);
            end
        end
    end

    // measurement sequencer: next state, counters and result capture
    always_comb begin
        state_d       = state_q;
        cur_chan_d    = cur_chan_q;
        trig_cnt_d    = trig_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        echo_cnt_d    = echo_cnt_q;
        res_chan_d    = res_chan_q;
        res_count_d   = res_count_q;
        res_timeout_d = res_timeout_q;
        unique case (state_q)
            S_IDLE: begin
                if (run && |chan_enable) begin
                    cur_chan_d = sel_here;
                    trig_cnt_d = '0;
                    state_d    = S_TRIGGER;
                end
            end
            S_TRIGGER: begin
                if (trig_cnt_q == TRG_LAST) begin
                    tmo_cnt_d  = '0;
                    echo_cnt_d = '0;
                    state_d    = S_WAIT_ECHO;
                end else begin
                    trig_cnt_d = trig_cnt_q + TRG_W'(1);
                end
            end
            S_WAIT_ECHO: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                // only a fresh 0->1 transition counts; an echo stuck high from before is ignored
                if (echo_cur && !echo_prev_q) begin
                    echo_cnt_d = COUNT_WIDTH'(1);
                    state_d    = S_ON_ECHO;
                end
                if (tmo_cnt_q == TMO_LAST) begin
                    res_chan_d    = cur_chan_q;
                    res_count_d   = echo_cnt_d;
                    res_timeout_d = 1'b1;
                    state_d       = S_REPORT;
                end
            end
            S_ON_ECHO: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (!echo_cur) begin
                    // echo fall takes priority over a coincident timeout
                    res_chan_d    = cur_chan_q;
                    res_count_d   = echo_cnt_q;
                    res_timeout_d = 1'b0;
                    state_d       = S_REPORT;
                end else begin
                    echo_cnt_d = echo_inc;
                    if (tmo_cnt_q == TMO_LAST) begin
                        res_chan_d    = cur_chan_q;
                        res_count_d   = echo_inc;
                        res_timeout_d = 1'b1;
                        state_d       = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                if (out_if.out_ready) begin
                    stall_cnt_d = '0;
                    state_d     = S_STALL;
                end
            end
            S_STALL: begin
                if (stall_cnt_q == STL_LAST) begin
                    cur_chan_d = sel_next;
                    trig_cnt_d = '0;
                    state_d    = (run && |chan_enable) ? S_TRIGGER : S_IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + STL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers; trigger and out_valid come straight from flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cur_chan_q    <= '0;
            trig_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            stall_cnt_q   <= '0;
            echo_cnt_q    <= '0;
            res_chan_q    <= '0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
            trigger_q     <= '0;
            out_valid_q   <= 1'b0;
            echo_prev_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_chan_q    <= cur_chan_d;
            trig_cnt_q    <= trig_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            echo_cnt_q    <= echo_cnt_d;
            res_chan_q    <= res_chan_d;
            res_count_q   <= res_count_d;
            res_timeout_q <= res_timeout_d;
            trigger_q     <= (state_d == S_TRIGGER) ? (NUM_CH'(1) << cur_chan_d) : '0;
            out_valid_q   <= (state_d == S_REPORT);
            echo_prev_q   <= echo_cur;
        end
    end

    assign trigger            = trigger_q;
    assign busy               = (state_q != S_IDLE);
    assign out_if.out_valid   = out_valid_q;
    assign out_if.out_chan    = res_chan_q;
    assign out_if.out_count   = res_count_q;
    assign out_if.out_timeout = res_timeout_q;
endmodule

// File: tb/tb_ultra_sonic_multi.sv
// tb/tb_ultra_sonic_multi.sv - scoreboard bench for ultra_sonic_multi
module tb_ultra_sonic_multi;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CW     = 16;
    localparam int TRIG   = 5;
    localparam int TMO    = 100;
    localparam int STALL  = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic [NUM_CH-1:0] chan_enable = '0;
    logic [NUM_CH-1:0] echo = '0;
    logic [NUM_CH-1:0] trigger;
    logic              busy;

    ultra_sonic_multi_if #(.CH_W(CH_W), .COUNT_WIDTH(CW)) bus ();

    ultra_sonic_multi #(
        .NUM_CH(NUM_CH), .COUNT_WIDTH(CW), .TRIGGER_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO), .STALL_CYCLES(STALL)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .chan_enable(chan_enable), .echo(echo),
        .trigger(trigger), .busy(busy), .out_if(bus)
    );

    always #10 clk = ~clk;

    typedef struct {
        int chan;
        int count;
        int tmo;
    } res_t;

    res_t exp_res[$];
    int   exp_trig[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // trigger monitor: channel order, one-hot, pulse width, silence while a result is pending
    int trig_prev_ch = -1;
    int trig_width = 0;
    always @(negedge clk) begin : trig_mon
        int ch;
        if (reset) begin
            trig_prev_ch = -1;
            trig_width = 0;
        end else if (trigger != '0) begin
            ch = 0;
            for (int i = 0; i < NUM_CH; i++) if (trigger[i]) ch = i;
            chk("trig_onehot", $countones(trigger), 1);
            chk("trig_during_report", bus.out_valid, 0);
            if (trig_prev_ch < 0) begin
                checks++;
                if (exp_trig.size() == 0) begin
                    failures++;
                    $display("FAIL trig_unexpected actual=ch%0d required=none", ch);
                end else begin
                    int e;
                    e = exp_trig.pop_front();
                    if (e != ch) begin
                        failures++;
                        $display("FAIL trig_chan actual=%0d required=%0d", ch, e);
                    end
                end
                trig_width = 1;
                trig_prev_ch = ch;
            end else begin
                trig_width++;
            end
        end else if (trig_prev_ch >= 0) begin
            chk("trig_width", trig_width, TRIG);
            trig_prev_ch = -1;
        end
    end

    // result monitor: stability under back-pressure and scoreboard compare on handshake
    logic            hold = 1'b0;
    logic [CH_W-1:0] h_chan;
    logic [CW-1:0]   h_count;
    logic            h_tmo;
    always @(negedge clk) begin : res_mon
        res_t e;
        if (reset) begin
            hold = 1'b0;
        end else if (bus.out_valid) begin
            if (hold) begin
                checks++;
                if (bus.out_chan !== h_chan || bus.out_count !== h_count || bus.out_timeout !== h_tmo) begin
                    failures++;
                    $display("FAIL res_stable actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                             bus.out_chan, bus.out_count, bus.out_timeout, h_chan, h_count, h_tmo);
                end
            end else begin
                hold = 1'b1;
                h_chan = bus.out_chan;
                h_count = bus.out_count;
                h_tmo = bus.out_timeout;
            end
            if (bus.out_ready) begin
                hold = 1'b0;
                checks++;
                if (exp_res.size() == 0) begin
                    failures++;
                    $display("FAIL res_unexpected actual=%0d/%0d/%0d required=none",
                             bus.out_chan, bus.out_count, bus.out_timeout);
                end else begin
                    e = exp_res.pop_front();
                    if (bus.out_chan !== CH_W'(e.chan) || bus.out_count !== CW'(e.count)
                        || bus.out_timeout !== e.tmo[0]) begin
                        failures++;
                        $display("FAIL res_value actual=%0d/%0d/%0d required=%0d/%0d/%0d",
                                 bus.out_chan, bus.out_count, bus.out_timeout, e.chan, e.count, e.tmo);
                    end
                end
            end
        end
    end

    task automatic push(input int ch, input int cnt, input int tmo);
        res_t r;
        r.chan = ch;
        r.count = cnt;
        r.tmo = tmo;
        exp_trig.push_back(ch);
        exp_res.push_back(r);
    endtask

    task automatic wait_trig_fall(input int ch);
        int n = 0;
        while (!trigger[ch] && n < 2000) begin @(negedge clk); n++; end
        while (trigger[ch] && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL wait_trig_fall actual=timeout required=pulse on ch%0d", ch);
        end
    endtask

    task automatic wait_res_done();
        int n = 0;
        while (exp_res.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL wait_result actual=timeout required=handshake");
        end
    endtask

    task automatic echo_pulse(input int ch, input int dly, input int len);
        repeat (dly) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (len) @(negedge clk);
        echo[ch] = 1'b0;
    endtask

    initial begin
        int n;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_trigger", trigger, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_chan", bus.out_chan, 0);
        chk("rst_count", bus.out_count, 0);
        chk("rst_timeout", bus.out_timeout, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        // ch0 echo 37 cycles, then mask down to channels 0 and 2
        push(0, 37, 0);
        chan_enable = 4'b1111;
        run = 1'b1;
        wait_trig_fall(0);
        chan_enable = 4'b0101;
        echo_pulse(0, 10, 37);
        wait_res_done();

        push(2, 7, 0);
        wait_trig_fall(2);
        echo_pulse(2, 3, 7);
        wait_res_done();

        // shortest echo: one cycle
        push(0, 1, 0);
        wait_trig_fall(0);
        echo_pulse(0, 0, 1);
        wait_res_done();

        // no echo on ch2: report exactly TMO cycles after trigger fall
        push(2, 0, 1);
        wait_trig_fall(2);
        n = 0;
        while (!bus.out_valid && n < 300) begin @(negedge clk); n++; end
        chk("timeout_latency", n, TMO);
        wait_res_done();

        // echo longer than the window: rises 12 counts in, 100-12 counted before timeout
        push(0, 88, 1);
        push(2, 0, 1);
        wait_trig_fall(0);
        echo_pulse(0, 10, 200);

        // back-pressure on the ch2 timeout report, then measure stall spacing
        @(posedge clk); #1 bus.out_ready = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 400) begin @(negedge clk); n++; end
        chk("bp_valid_seen", bus.out_valid, 1);
        repeat (50) @(negedge clk);
        chk("bp_still_valid", bus.out_valid, 1);
        push(0, 30, 0);
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (trigger == '0 && n < 100) begin @(negedge clk); n++; end
        chk("stall_spacing", n, STALL + 1);

        // drop run in the middle of the echo: report completes, then idle
        wait_trig_fall(0);
        echo_pulse(0, 2, 15);
        run = 1'b0;
        echo_pulse(0, 0, 15);
        wait_res_done();
        repeat (STALL + 5) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_trigger", trigger, 0);

        // restart resumes on ch2, reset lands mid-trigger
        exp_trig.push_back(2);
        run = 1'b1;
        n = 0;
        while (!trigger[2] && n < 200) begin @(negedge clk); n++; end
        chk("restart_trig_ch2", trigger[2], 1);
        @(posedge clk); #1 reset = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        chk("rst2_trigger", trigger, 0);
        chk("rst2_valid", bus.out_valid, 0);
        chk("rst2_chan", bus.out_chan, 0);
        chk("rst2_count", bus.out_count, 0);
        chk("rst2_timeout", bus.out_timeout, 0);
        chk("rst2_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_busy", busy, 0);
        chk("left_trig", exp_trig.size(), 0);
        chk("left_res", exp_res.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
